collision_event_writer: RTL
===========================

Name: collision_event_writer

Overview:
- Producer side of the collision lookup table: accepts sprite-pair collision events from the sprite renderer and serializes them into single-cycle table writes (write_collision / table_index / table_value).
- Each pair (A,B) yields up to two writes: entry A <- B, then entry B <- A.
- First collision per sprite wins until the next clear; later writes for that sprite are suppressed.
- A small FIFO absorbs bursts, since the renderer cannot stall mid-scanline.

Parameters:
SPRITE_WIDTH, 8, width of a sprite index and of table_index
NUM_SPRITES, 128, number of valid sprites; indices >= NUM_SPRITES are ignored
DATA_WIDTH, 8, width of table_value
FIFO_DEPTH, 4, pair-event FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock
reg_reset  in  1  asynchronous active-high reset; also the per-frame / MPU collision clear
event_valid  in  1  renderer presents a collision pair
event_ready  out  1  FIFO can accept a pair
sprite_a  in  SPRITE_WIDTH  first sprite of pair
sprite_b  in  SPRITE_WIDTH  second sprite of pair
write_collision  out  1  one-cycle table write strobe
table_index  out  SPRITE_WIDTH  entry being written (sprite index)
table_value  out  DATA_WIDTH  partner sprite index, zero-extended
busy  out  1  FIFO non-empty or FSM not IDLE
overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset: reg_reset (async, active-high, clock clk) clears FIFO, FSM -> IDLE, recorded[] bitmap, overflow. Effect is immediate.
- Reset values: write_collision=0, table_index=0, table_value=0, busy=0, overflow=0, event_ready=1.
- Reset mid-drain: pending writes are lost; no partial write follows.
- Acceptance:
  - event_ready = !full, derived from the registered count. A pop in the same cycle does not free space for a push.
  - On event_valid & event_ready, the pair is pushed unless a discard rule applies.
  - Discard rules: sprite_a == sprite_b; either index >= NUM_SPRITES. Discarded events consume no slot and do not set overflow.
  - event_valid & !event_ready: event dropped, overflow <= 1 (sticky until reg_reset).
- FSM states: IDLE, WR_A, WR_B.
  - IDLE: if FIFO non-empty, pop head into cur_a/cur_b -> WR_A.
  - WR_A: if !recorded[cur_a], register write (index=cur_a, value=cur_b) and set recorded[cur_a]. -> WR_B.
  - WR_B: if !recorded[cur_b], register write (index=cur_b, value=cur_a) and set recorded[cur_b]. Then, if FIFO non-empty, pop directly into cur_a/cur_b -> WR_A; else -> IDLE.
- Outputs are registered. write_collision is high for exactly one cycle per issued write and is low in cycles where a write is suppressed. table_index/table_value hold their last values when the strobe is low.
- Latency: event accepted at edge N into an empty, idle block -> pop at N+1 -> first write_collision high after edge N+2, second after N+3.
- Sustained throughput: one pair per 2 cycles.
- Dedup: recorded[] has NUM_SPRITES bits.
  - Within one pair, WR_A's set is visible to WR_B (matters only if a discard rule fails; a==b never reaches the FSM).
  - Pair (A,B) where A is already recorded still writes B <- A if B is unrecorded.
- Width rules:
  - table_value = {zeros, partner}; partner truncated to DATA_WIDTH if SPRITE_WIDTH > DATA_WIDTH.
  - FIFO pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- busy = (state != IDLE) | (count != 0).

Test Plan:
- After reset, push (3,7) at edge N -> write_collision high after N+2 with index=3/value=7, then after N+3 with index=7/value=3; busy falls after the last write; overflow=0.
- Push (3,7) then (3,9) -> writes 3<-7, 7<-3, 9<-3 only; the 3<-9 write is suppressed (strobe low in that slot).
- Push (5,5) and (200,1) with NUM_SPRITES=128 -> no writes, no FIFO occupancy, overflow=0.
- Hold event_valid with 6 distinct pairs back-to-back, FIFO_DEPTH=4 -> event_ready deasserts once full; overflow=1; exactly the accepted pairs are written at 2 cycles/pair in order.
- Assert reg_reset during the WR_A of a queued pair -> write_collision=0 immediately, busy=0, event_ready=1. Re-push the same pair -> both writes reissued (recorded[] cleared).
- Simultaneous pop and push while full -> push is refused (event_ready=0 that cycle), overflow=1; next cycle event_ready=1.

Source files
------------

// File: rtl/collision_event_writer.sv
// Collision table producer: queues sprite-pair events and turns each pair
// into up to two deduplicated single-cycle table writes.
module collision_event_writer #(
  parameter int unsigned SPRITE_WIDTH = 8,
  parameter int unsigned NUM_SPRITES  = 128,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reg_reset,
  input  logic                    event_valid,
  output logic                    event_ready,
  input  logic [SPRITE_WIDTH-1:0] sprite_a,
  input  logic [SPRITE_WIDTH-1:0] sprite_b,
  output logic                    write_collision,
  output logic [SPRITE_WIDTH-1:0] table_index,
  output logic [DATA_WIDTH-1:0]   table_value,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW =
    (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned RN = 2 ** RW;
  localparam logic [SPRITE_WIDTH:0] NS =
    NUM_SPRITES[SPRITE_WIDTH:0];
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    WR_A,
    WR_B
  } state_t;

  state_t state, state_nx;

  logic [SPRITE_WIDTH-1:0] fifo_a [FIFO_DEPTH];
  logic [SPRITE_WIDTH-1:0] fifo_b [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic [SPRITE_WIDTH-1:0] cur_a, cur_b;
  logic [RN-1:0]           recorded;
  logic [RW-1:0]           ia, ib;
  logic [DATA_WIDTH-1:0]   val_a, val_b;
  logic                    discard, push, pop;

  assign event_ready = (count != FULL);
  assign discard = (sprite_a == sprite_b)
                 | ({1'b0, sprite_a} >= NS)
                 | ({1'b0, sprite_b} >= NS);
  assign push = event_valid & event_ready & ~discard;
  assign pop  = ((state == IDLE) | (state == WR_B))
              & (count != '0);
  assign busy = (state != IDLE) | (count != '0);

  // Queued indices are always < NUM_SPRITES, so the low bits suffice.
  assign ia = cur_a[RW-1:0];
  assign ib = cur_b[RW-1:0];

  if (DATA_WIDTH > SPRITE_WIDTH) begin : g_ext
    assign val_a = {{(DATA_WIDTH-SPRITE_WIDTH){1'b0}}, cur_a};
    assign val_b = {{(DATA_WIDTH-SPRITE_WIDTH){1'b0}}, cur_b};
  end else begin : g_trunc
    assign val_a = cur_a[DATA_WIDTH-1:0];
    assign val_b = cur_b[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pop) state_nx = WR_A;
      WR_A:    state_nx = WR_B;
      WR_B:    state_nx = pop ? WR_A : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= sprite_a;
      fifo_b[wr_ptr] <= sprite_b;
    end
  end

  always_ff @(posedge clk or posedge reg_reset) begin
    if (reg_reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      cur_a           <= '0;
      cur_b           <= '0;
      recorded        <= '0;
      overflow        <= 1'b0;
      write_collision <= 1'b0;
      table_index     <= '0;
      table_value     <= '0;
    end else begin
      state           <= state_nx;
      write_collision <= 1'b0;
      if (event_valid & ~event_ready) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur_a  <= fifo_a[rd_ptr];
        cur_b  <= fifo_b[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // First collision per sprite wins until the next clear.
      if (state == WR_A && !recorded[ia]) begin
        write_collision <= 1'b1;
        table_index     <= cur_a;
        table_value     <= val_b;
        recorded[ia]    <= 1'b1;
      end
      if (state == WR_B && !recorded[ib]) begin
        write_collision <= 1'b1;
        table_index     <= cur_b;
        table_value     <= val_a;
        recorded[ib]    <= 1'b1;
      end
    end
  end

endmodule
